systolic_row_ctrl: RTL

Sequencing controller for the weight-stationary PE array built from `PE_row` instances. It runs one job per `start`:
- loads a fresh NUM×NUM weight tile through the array's W_EN path into the shadow weight bank;
- flips SELECTOR so the array computes with the new tile;
- streams `cfg_len` activation vectors into the array;
- frames the skewed result window with `out_valid`.

It owns every array-level control line (EN, W_EN, SELECTOR, OPSEL) plus the read strobes to the weight and activation buffers.

---
 rtl/systolic_row_ctrl_if.sv | 39 +++
 rtl/systolic_row_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/systolic_row_ctrl_if.sv
// Control/handshake bundle between the job host and the systolic row
// controller. The host drives the job request and configuration; the
// controller drives the array control lines and buffer read strobes.
interface systolic_row_ctrl_if #(
   parameter int NUM   = 16,
   parameter int LEN_W = 16
);
   localparam int AW = (NUM > 1) ? $clog2(NUM) : 1;

   logic             start;
   logic             abort;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_opsel;
   logic             cfg_reuse_w;

   logic             w_rd_en;
   logic [AW-1:0]    w_rd_addr;
   logic             act_rd_en;
   logic [LEN_W-1:0] act_rd_addr;
   logic             EN;
   logic             W_EN;
   logic             SELECTOR;
   logic             OPSEL;
   logic             out_valid;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, cfg_len, cfg_opsel, cfg_reuse_w,
      input  w_rd_en, w_rd_addr, act_rd_en, act_rd_addr, EN, W_EN,
             SELECTOR, OPSEL, out_valid, busy, done
   );

   modport slave (
      input  start, abort, cfg_len, cfg_opsel, cfg_reuse_w,
      output w_rd_en, w_rd_addr, act_rd_en, act_rd_addr, EN, W_EN,
             SELECTOR, OPSEL, out_valid, busy, done
   );
endinterface

// File: rtl/systolic_row_ctrl.sv
// Job sequencer for the weight-stationary PE array: weight tile load into
// the shadow bank, bank swap, activation streaming and result framing.
//
// state | meaning
// IDLE  | waiting for start with a non-zero vector count
// LOAD  | reading weight rows 0..NUM-1 into the shadow bank
// SWAP  | last weight row lands; active bank flips at the end
// RUN   | streaming activations and framing the skewed result window
// DONE  | one-cycle completion pulse
module systolic_row_ctrl #(
   parameter int NUM   = 16,
   parameter int LEN_W = 16
) (
   input logic               CLK,
   input logic               RESET,
   systolic_row_ctrl_if.slave bus
);
   localparam int AW = (NUM > 1) ? $clog2(NUM) : 1;
   // Run counter must reach cfg_len + 2*NUM - 1 for the largest cfg_len.
   localparam int CW = $clog2((2 ** LEN_W) + 2 * NUM);

   typedef enum logic [2:0] {IDLE, LOAD, SWAP, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    w_q, w_d;
   logic [CW-1:0]    c_q, c_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             opsel_q, opsel_d;
   logic             sel_q, sel_d;

   logic             w_rd_en_q, w_rd_en_d;
   logic [AW-1:0]    w_rd_addr_q, w_rd_addr_d;
   logic             act_rd_en_q, act_rd_en_d;
   logic [LEN_W-1:0] act_rd_addr_q, act_rd_addr_d;
   logic             en_q, en_d;
   logic             w_en_q, w_en_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [CW-1:0]    run_last;
   logic [CW-1:0]    lenx_d;

   assign run_last = CW'(len_q) + CW'(2 * NUM - 1);
   assign lenx_d   = CW'(len_d);

   // Next-state, counters and the registered-output next values.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      c_d     = c_q;
      len_d   = len_q;
      opsel_d = opsel_q;
      sel_d   = sel_q;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort && (bus.cfg_len != '0)) begin
               len_d   = bus.cfg_len;
               opsel_d = bus.cfg_opsel;
               w_d     = '0;
               c_d     = '0;
               state_d = bus.cfg_reuse_w ? RUN : LOAD;
            end
         end
         LOAD: begin
            if (w_q == AW'(NUM - 1)) state_d = SWAP;
            else                     w_d     = w_q + AW'(1);
         end
         SWAP: begin
            state_d = RUN;
            c_d     = '0;
            sel_d   = ~sel_q;
         end
         RUN: begin
            if (c_q == run_last) state_d = DONE;
            else                 c_d     = c_q + CW'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort keeps the old bank: a half-written shadow bank is never activated.
      if (bus.abort && (state_q != IDLE)) begin
         state_d = IDLE;
         sel_d   = sel_q;
      end

      w_rd_en_d     = (state_d == LOAD);
      w_rd_addr_d   = (state_d == LOAD) ? w_d : '0;
      // Weight buffer has one cycle of read latency, so the shift follows the read.
      w_en_d        = w_rd_en_q && (state_d != IDLE);
      en_d          = (state_d == RUN);
      act_rd_en_d   = en_d && (c_d < lenx_d);
      act_rd_addr_d = act_rd_en_d ? c_d[LEN_W-1:0] : '0;
      out_valid_d   = en_d && (c_d >= CW'(2 * NUM)) && (c_d < (lenx_d + CW'(2 * NUM)));
      busy_d        = (state_d != IDLE);
      done_d        = (state_d == DONE);
   end

   // State, counters, latched configuration and all outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= IDLE;
         w_q           <= '0;
         c_q           <= '0;
         len_q         <= '0;
         opsel_q       <= 1'b0;
         sel_q         <= 1'b0;
         w_rd_en_q     <= 1'b0;
         w_rd_addr_q   <= '0;
         act_rd_en_q   <= 1'b0;
         act_rd_addr_q <= '0;
         en_q          <= 1'b0;
         w_en_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         w_q           <= w_d;
         c_q           <= c_d;
         len_q         <= len_d;
         opsel_q       <= opsel_d;
         sel_q         <= sel_d;
         w_rd_en_q     <= w_rd_en_d;
         w_rd_addr_q   <= w_rd_addr_d;
         act_rd_en_q   <= act_rd_en_d;
         act_rd_addr_q <= act_rd_addr_d;
         en_q          <= en_d;
         w_en_q        <= w_en_d;
         out_valid_q   <= out_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bus.w_rd_en     = w_rd_en_q;
   assign bus.w_rd_addr   = w_rd_addr_q;
   assign bus.act_rd_en   = act_rd_en_q;
   assign bus.act_rd_addr = act_rd_addr_q;
   assign bus.EN          = en_q;
   assign bus.W_EN        = w_en_q;
   assign bus.SELECTOR    = sel_q;
   assign bus.OPSEL       = opsel_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
endmodule
